// File: rtl/relogio_bcd_counter_if.sv
// Control and display bus between the HH:MM:SS timekeeping stage and its neighbours.
// The master drives set-mode and increment pulses and receives the six BCD digits
// and the 1 Hz tick.
interface relogio_bcd_counter_if;
    logic       set_mode;
    logic       inc_hour;
    logic       inc_min;
    logic [3:0] s_lsd_bcd;
    logic [3:0] s_msd_bcd;
    logic [3:0] m_lsd_bcd;
    logic [3:0] m_msd_bcd;
    logic [3:0] h_lsd_bcd;
    logic [3:0] h_msd_bcd;
    logic       tick_1hz;

    modport master (
        output set_mode, inc_hour, inc_min,
        input  s_lsd_bcd, s_msd_bcd, m_lsd_bcd, m_msd_bcd, h_lsd_bcd, h_msd_bcd, tick_1hz
    );

    modport slave (
        input  set_mode, inc_hour, inc_min,
        output s_lsd_bcd, s_msd_bcd, m_lsd_bcd, m_msd_bcd, h_lsd_bcd, h_msd_bcd, tick_1hz
    );
endinterface

// File: rtl/relogio_bcd_counter.sv
// Time base and BCD timekeeping for the HH:MM:SS clock: divides main_clock into a
// 1 Hz tick, keeps hours/minutes/seconds as six BCD digits and supports a set mode
// in which time is frozen and hours/minutes can be stepped.
module relogio_bcd_counter #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
    input  logic                 main_clock,
    input  logic                 main_reset,
    relogio_bcd_counter_if.slave bus
);
    localparam int unsigned     CntW    = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [CntW-1:0] TermCnt = CntW'(CLK_FREQ_HZ - 1);

    logic [CntW-1:0] presc_q, presc_d;
    logic            tick_q, tick_d;
    logic [3:0]      s_lsd_q, s_lsd_d, s_msd_q, s_msd_d;
    logic [3:0]      m_lsd_q, m_lsd_d, m_msd_q, m_msd_d;
    logic [3:0]      h_lsd_q, h_lsd_d, h_msd_q, h_msd_d;

    // Two-digit BCD increment modulo 60, result as {msd, lsd}.
    function automatic logic [7:0] inc_mod60(input logic [3:0] msd, input logic [3:0] lsd);
        logic [3:0] new_msd;
        logic [3:0] new_lsd;
        new_msd = msd;
        new_lsd = lsd + 4'd1;
        if (lsd == 4'd9) begin
            new_lsd = 4'd0;
            new_msd = (msd == 4'd5) ? 4'd0 : msd + 4'd1;
        end
        return {new_msd, new_lsd};
    endfunction

    // Two-digit BCD increment modulo 24, result as {msd, lsd}.
    function automatic logic [7:0] inc_mod24(input logic [3:0] msd, input logic [3:0] lsd);
        logic [3:0] new_msd;
        logic [3:0] new_lsd;
        new_msd = msd;
        new_lsd = lsd + 4'd1;
        if (msd == 4'd2 && lsd == 4'd3) begin
            new_msd = 4'd0;
            new_lsd = 4'd0;
        end else if (lsd == 4'd9) begin
            new_lsd = 4'd0;
            new_msd = msd + 4'd1;
        end
        return {new_msd, new_lsd};
    endfunction

    // Next-state: set mode freezes the prescaler and seconds, otherwise the
    // terminal count ticks and ripples the carry chain in a single edge.
    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        s_lsd_d = s_lsd_q;
        s_msd_d = s_msd_q;
        m_lsd_d = m_lsd_q;
        m_msd_d = m_msd_q;
        h_lsd_d = h_lsd_q;
        h_msd_d = h_msd_q;
        if (bus.set_mode) begin
            presc_d = '0;
            s_lsd_d = 4'd0;
            s_msd_d = 4'd0;
            if (bus.inc_min) begin
                {m_msd_d, m_lsd_d} = inc_mod60(m_msd_q, m_lsd_q);
            end
            if (bus.inc_hour) begin
                {h_msd_d, h_lsd_d} = inc_mod24(h_msd_q, h_lsd_q);
            end
        end else if (presc_q == TermCnt) begin
            presc_d = '0;
            tick_d  = 1'b1;
            {s_msd_d, s_lsd_d} = inc_mod60(s_msd_q, s_lsd_q);
            if ({s_msd_q, s_lsd_q} == 8'h59) begin
                {m_msd_d, m_lsd_d} = inc_mod60(m_msd_q, m_lsd_q);
                if ({m_msd_q, m_lsd_q} == 8'h59) begin
                    {h_msd_d, h_lsd_d} = inc_mod24(h_msd_q, h_lsd_q);
                end
            end
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // State register with asynchronous clear to 00:00:00.
    always_ff @(posedge main_clock or negedge main_reset) begin
        if (!main_reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            s_lsd_q <= 4'd0;
            s_msd_q <= 4'd0;
            m_lsd_q <= 4'd0;
            m_msd_q <= 4'd0;
            h_lsd_q <= 4'd0;
            h_msd_q <= 4'd0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            s_lsd_q <= s_lsd_d;
            s_msd_q <= s_msd_d;
            m_lsd_q <= m_lsd_d;
            m_msd_q <= m_msd_d;
            h_lsd_q <= h_lsd_d;
            h_msd_q <= h_msd_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        bus.s_lsd_bcd = s_lsd_q;
        bus.s_msd_bcd = s_msd_q;
        bus.m_lsd_bcd = m_lsd_q;
        bus.m_msd_bcd = m_msd_q;
        bus.h_lsd_bcd = h_lsd_q;
        bus.h_msd_bcd = h_msd_q;
        bus.tick_1hz  = tick_q;
    end
endmodule

// File: tb/tb_relogio_bcd_counter.sv
// Self-checking bench for relogio_bcd_counter with a 4-cycle time base.
// Expected time is modelled as integer seconds of the day plus a cycle count.
module tb_relogio_bcd_counter;
    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic main_reset;

    relogio_bcd_counter_if bus ();

    relogio_bcd_counter #(.CLK_FREQ_HZ(N)) dut (
        .main_clock (clk),
        .main_reset (main_reset),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int m_t    = 0;
    int m_cnt  = 0;
    bit m_tick = 1'b0;

    typedef struct {
        logic set_mode;
        logic inc_hour;
        logic inc_min;
        int   exp_t;
        logic exp_tick;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [23:0] to_bcd(input int t);
        int h;
        int mi;
        int s;
        h  = t / 3600;
        mi = (t / 60) % 60;
        s  = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic int hms(input int h, input int mi, input int s);
        return h * 3600 + mi * 60 + s;
    endfunction

    function automatic logic [23:0] dut_digits();
        return {bus.h_msd_bcd, bus.h_lsd_bcd, bus.m_msd_bcd, bus.m_lsd_bcd,
                bus.s_msd_bcd, bus.s_lsd_bcd};
    endfunction

    task automatic model_edge();
        int h;
        int mi;
        if (!main_reset) return;
        if (bus.set_mode) begin
            h  = m_t / 3600;
            mi = (m_t / 60) % 60;
            if (bus.inc_min)  mi = (mi + 1) % 60;
            if (bus.inc_hour) h  = (h + 1) % 24;
            m_t    = hms(h, mi, 0);
            m_cnt  = 0;
            m_tick = 1'b0;
        end else if (m_cnt == N - 1) begin
            m_cnt  = 0;
            m_tick = 1'b1;
            m_t    = (m_t + 1) % 86400;
        end else begin
            m_cnt  = m_cnt + 1;
            m_tick = 1'b0;
        end
    endtask

    task automatic check_const(input string name, input int exp_t, input logic exp_tick);
        n_checks++;
        if (dut_digits() !== to_bcd(exp_t) || bus.tick_1hz !== exp_tick) begin
            n_fail++;
            $display("FAIL %s: got digits %h tick %b, expected digits %h tick %b",
                     name, dut_digits(), bus.tick_1hz, to_bcd(exp_t), exp_tick);
        end
    endtask

    task automatic step(input string name);
        @(posedge clk);
        model_edge();
        #1;
        check_const(name, m_t, m_tick);
    endtask

    task automatic run(input int n);
        bus.set_mode = 1'b0;
        bus.inc_hour = 1'b0;
        bus.inc_min  = 1'b0;
        for (int i = 0; i < n; i++) step("run");
    endtask

    task automatic pulse(input logic h, input logic mi);
        bus.inc_hour = h;
        bus.inc_min  = mi;
        step("pulse");
        bus.inc_hour = 1'b0;
        bus.inc_min  = 1'b0;
        step("pulse_gap");
    endtask

    // Called at a point away from the clock edge.
    task automatic do_reset();
        main_reset = 1'b0;
        m_t    = 0;
        m_cnt  = 0;
        m_tick = 1'b0;
        #1;
        check_const("reset_async", 0, 1'b0);
        step("reset_hold");
        step("reset_hold");
        bus.set_mode = 1'b0;
        bus.inc_hour = 1'b0;
        bus.inc_min  = 1'b0;
        main_reset   = 1'b1;
    endtask

    task automatic preload(input int h, input int mi);
        bus.set_mode = 1'b1;
        step("set_enter");
        for (int i = 0; i < h; i++) pulse(1'b1, 1'b0);
        for (int i = 0; i < mi; i++) pulse(1'b0, 1'b1);
    endtask

    initial begin
        main_reset   = 1'b0;
        bus.set_mode = 1'b0;
        bus.inc_hour = 1'b0;
        bus.inc_min  = 1'b0;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 2, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 60, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 3660, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 7320, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 7320, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 7320, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 7320, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 7321, 1'b1};

        // Table-driven start-up, set-mode entry and exit.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.set_mode = vecs[i].set_mode;
            bus.inc_hour = vecs[i].inc_hour;
            bus.inc_min  = vecs[i].inc_min;
            @(posedge clk);
            model_edge();
            #1;
            check_const($sformatf("vec%0d", i), vecs[i].exp_t, vecs[i].exp_tick);
        end

        // Seconds carry and first minute.
        do_reset();
        run(40);
        check_const("ten_seconds", 10, 1'b1);
        run(200);
        check_const("one_minute", hms(0, 1, 0), 1'b1);

        // Set mode at 12:34:56.
        do_reset();
        preload(12, 34);
        run(224);
        check_const("at_12_34_56", hms(12, 34, 56), 1'b1);
        bus.set_mode = 1'b1;
        step("set_at_12_34");
        check_const("secs_zeroed", hms(12, 34, 0), 1'b0);
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1);
        check_const("inc_min_x3", hms(12, 37, 0), 1'b0);
        for (int i = 0; i < 12; i++) pulse(1'b1, 1'b0);
        check_const("inc_hour_x12", hms(0, 37, 0), 1'b0);

        // Day wrap.
        do_reset();
        preload(23, 59);
        run(236);
        check_const("at_23_59_59", hms(23, 59, 59), 1'b1);
        run(4);
        check_const("day_wrap", 0, 1'b1);

        // Hour tens carry from running time.
        do_reset();
        preload(9, 59);
        run(240);
        check_const("hour_9_to_10", hms(10, 0, 0), 1'b1);

        // Simultaneous increments: no minute carry into hours.
        do_reset();
        preload(5, 59);
        bus.inc_hour = 1'b1;
        bus.inc_min  = 1'b1;
        step("both_inc");
        check_const("both_inc_06_00", hms(6, 0, 0), 1'b0);

        // Set mode rising on the terminal-count cycle.
        do_reset();
        run(239);
        check_const("before_tc", 59, 1'b0);
        bus.set_mode = 1'b1;
        step("set_at_tc");
        check_const("set_wins_tc", 0, 1'b0);

        // Reset in the cycle tick is high, mid-prescale.
        do_reset();
        run(8);
        check_const("pre_reset_tick", 2, 1'b1);
        do_reset();
        run(3);
        check_const("post_reset_quiet", 0, 1'b0);
        run(1);
        check_const("post_reset_tick", 1, 1'b1);

        // Reset in set mode.
        do_reset();
        preload(7, 15);
        do_reset();
        run(4);
        check_const("set_reset_tick", 1, 1'b1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) bus.set_mode = ~bus.set_mode;
            bus.inc_hour = ($urandom_range(0, 3) == 0);
            bus.inc_min  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step("random");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
